// File: rtl/ff_weight_sequencer_pkg.sv
// Shared definitions for the feed-forward weight sequencer and the weight-update block:
// layer encoding, sequencer state type, and per-layer word count / base address helpers.
package ff_weight_sequencer_pkg;

  localparam logic [1:0] LAYER_IN  = 2'd0;
  localparam logic [1:0] LAYER_H1  = 2'd1;
  localparam logic [1:0] LAYER_H2  = 2'd2;
  localparam logic [1:0] LAYER_OUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  // Each node carries one weight per input plus one bias weight.
  function automatic int layer_count(input logic [1:0] layer, input int n_in, input int n_h1,
                                     input int n_h2, input int n_out);
    case (layer)
      LAYER_H1:  return (n_in + 1) * n_h1;
      LAYER_H2:  return (n_h1 + 1) * n_h2;
      LAYER_OUT: return (n_h2 + 1) * n_out;
      default:   return 0;
    endcase
  endfunction

  function automatic int layer_base(input logic [1:0] layer, input int n_in, input int n_h1,
                                    input int n_h2, input int n_out);
    case (layer)
      LAYER_H2:  return layer_count(LAYER_H1, n_in, n_h1, n_h2, n_out);
      LAYER_OUT: return layer_count(LAYER_H1, n_in, n_h1, n_h2, n_out)
                      + layer_count(LAYER_H2, n_in, n_h1, n_h2, n_out);
      default:   return 0;
    endcase
  endfunction

  function automatic int total_count(input int n_in, input int n_h1, input int n_h2,
                                     input int n_out);
    return layer_count(LAYER_H1, n_in, n_h1, n_h2, n_out)
         + layer_count(LAYER_H2, n_in, n_h1, n_h2, n_out)
         + layer_count(LAYER_OUT, n_in, n_h1, n_h2, n_out);
  endfunction

endpackage

// File: rtl/ff_weight_sequencer_if.sv
// Weight RAM read port: the sequencer drives the strobe and address, the RAM returns data one cycle later.
interface ff_weight_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  o_mem_rd_en;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;

  modport master (output o_mem_rd_en, output o_mem_addr, input i_mem_data);
  modport slave  (input o_mem_rd_en, input o_mem_addr, output i_mem_data);
endinterface

// File: rtl/ff_rd_pipe.sv
// Two-stage read-return pipeline: RAM latency stage plus output register, with a count of
// reads still in flight so the sequencer knows when a burst has fully drained.
module ff_rd_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] weight,
  output logic                  weight_valid,
  output logic                  idle
);

  logic       data_valid;
  logic [1:0] in_flight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid   <= 1'b0;
      weight_valid <= 1'b0;
      weight       <= '0;
      in_flight    <= 2'd0;
    end else begin
      data_valid   <= rd_en;
      weight_valid <= data_valid;
      if (data_valid) weight <= mem_data;
      // A read stays counted until its word moves into the output register.
      in_flight <= in_flight + {1'b0, rd_en} - {1'b0, data_valid};
    end
  end

  assign idle = (in_flight == 2'd0);

endmodule

// File: rtl/ff_weight_sequencer.sv
// Streams one layer's weights (node-major, bias last per node) from the weight RAM on each request.
//   state    | meaning
//   ST_IDLE  | waiting for a legal layer request
//   ST_FETCH | issuing RAM reads, one per cycle unless held
//   ST_DRAIN | all reads issued, waiting for the last word to leave the pipeline
module ff_weight_sequencer
  import ff_weight_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int N_IN        = 2,
  parameter int N_H1        = 5,
  parameter int N_H2        = 5,
  parameter int N_OUT       = 3,
  parameter int TARGET_BASE = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_net_sel,
  input  logic                  i_layer_req,
  input  logic [1:0]            i_layer,
  input  logic                  i_hold,
  ff_weight_sequencer_if.master mem,
  output logic [DATA_WIDTH-1:0] o_weight,
  output logic                  o_weight_valid,
  output logic                  o_busy,
  output logic                  o_layer_done,
  output logic                  o_pass_done,
  output logic                  o_error
);

  localparam int TOTAL = total_count(N_IN, N_H1, N_H2, N_OUT);

  localparam logic [ADDR_WIDTH-1:0] C1 = ADDR_WIDTH'(layer_count(LAYER_H1, N_IN, N_H1, N_H2, N_OUT));
  localparam logic [ADDR_WIDTH-1:0] C2 = ADDR_WIDTH'(layer_count(LAYER_H2, N_IN, N_H1, N_H2, N_OUT));
  localparam logic [ADDR_WIDTH-1:0] C3 = ADDR_WIDTH'(layer_count(LAYER_OUT, N_IN, N_H1, N_H2, N_OUT));
  localparam logic [ADDR_WIDTH-1:0] B1 = ADDR_WIDTH'(layer_base(LAYER_H1, N_IN, N_H1, N_H2, N_OUT));
  localparam logic [ADDR_WIDTH-1:0] B2 = ADDR_WIDTH'(layer_base(LAYER_H2, N_IN, N_H1, N_H2, N_OUT));
  localparam logic [ADDR_WIDTH-1:0] B3 = ADDR_WIDTH'(layer_base(LAYER_OUT, N_IN, N_H1, N_H2, N_OUT));
  localparam logic [ADDR_WIDTH-1:0] TB = ADDR_WIDTH'(TARGET_BASE);

  // The banks must not overlap and the target bank must fit the address space; no runtime wrap exists.
  if (TARGET_BASE < TOTAL || TARGET_BASE + TOTAL > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("ff_weight_sequencer: TARGET_BASE/ADDR_WIDTH cannot hold both weight banks");
  end

  seq_state_t            state;
  logic [1:0]            layer_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] bank_off;
  logic                  fetching;
  logic                  pipe_idle;
  logic                  err_req;
  logic                  pass_set;

  assign fetching        = (state == ST_FETCH);
  assign mem.o_mem_rd_en = fetching && !i_hold;
  assign mem.o_mem_addr  = fetching ? base_q + rd_cnt : '0;
  assign o_busy          = (state != ST_IDLE);
  assign bank_off        = i_net_sel ? TB : '0;
  assign err_req         = i_layer_req && ((state != ST_IDLE) || (i_layer == LAYER_IN));
  assign pass_set        = (state == ST_DRAIN) && pipe_idle && (layer_q == LAYER_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      layer_q      <= LAYER_IN;
      base_q       <= '0;
      count_q      <= '0;
      rd_cnt       <= '0;
      o_layer_done <= 1'b0;
      o_pass_done  <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_layer_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_layer_req && (i_layer != LAYER_IN)) begin
            layer_q <= i_layer;
            rd_cnt  <= '0;
            state   <= ST_FETCH;
            case (i_layer)
              LAYER_H1: begin base_q <= B1 + bank_off; count_q <= C1; end
              LAYER_H2: begin base_q <= B2 + bank_off; count_q <= C2; end
              default:  begin base_q <= B3 + bank_off; count_q <= C3; end
            endcase
          end
        end
        ST_FETCH: begin
          if (!i_hold) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == count_q - 1'b1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_idle) begin
            o_layer_done <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A new pass clears the sticky flags even if a completion lands in the same cycle.
      if (i_start) begin
        o_error     <= 1'b0;
        o_pass_done <= 1'b0;
      end else begin
        if (err_req)  o_error     <= 1'b1;
        if (pass_set) o_pass_done <= 1'b1;
      end
    end
  end

  ff_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (mem.o_mem_rd_en),
    .mem_data    (mem.i_mem_data),
    .weight      (o_weight),
    .weight_valid(o_weight_valid),
    .idle        (pipe_idle)
  );

endmodule

// File: tb/tb_ff_weight_sequencer.sv
// Directed bench for ff_weight_sequencer with a behavioural synchronous-read weight RAM.
module tb_ff_weight_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_net_sel, i_layer_req, i_hold;
  logic [1:0]  i_layer;
  logic [31:0] o_weight;
  logic        o_weight_valid, o_busy, o_layer_done, o_pass_done, o_error;

  logic [31:0] ram [256];

  int checks = 0;
  int errors = 0;

  int n_rd, n_w, first_rd, first_v, last_v, done_cyc, addr_bad, data_bad;
  int total_words, done_pulses;

  ff_weight_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) mem_if ();

  ff_weight_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_net_sel     (i_net_sel),
    .i_layer_req   (i_layer_req),
    .i_layer       (i_layer),
    .i_hold        (i_hold),
    .mem           (mem_if),
    .o_weight      (o_weight),
    .o_weight_valid(o_weight_valid),
    .o_busy        (o_busy),
    .o_layer_done  (o_layer_done),
    .o_pass_done   (o_pass_done),
    .o_error       (o_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_if.o_mem_rd_en) mem_if.i_mem_data <= ram[mem_if.o_mem_addr];
  end

  function automatic logic [31:0] ram_word(input int a);
    return 32'h4000_0000 + 32'(a) * 32'h0001_0003;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows the burst to its layer_done pulse (or a 200-cycle budget).
  task automatic run_burst(input string tag, input logic [1:0] layer, input logic sel,
                           input int base, input int cnt, input int hold_at, input int hold_len,
                           input int err_at, input logic [1:0] err_layer);
    i_layer_req = 1'b1;
    i_layer     = layer;
    i_net_sel   = sel;
    @(posedge clk); #1;
    i_layer_req = 1'b0;
    i_net_sel   = ~sel;
    n_rd = 0; n_w = 0; first_rd = -1; first_v = -1; last_v = -1; done_cyc = -1;
    addr_bad = 0; data_bad = 0;
    for (int k = 0; k < 200 && done_cyc < 0; k++) begin
      i_hold      = (k >= hold_at) && (k < hold_at + hold_len);
      i_layer_req = (k == err_at);
      i_layer     = (k == err_at) ? err_layer : layer;
      #1;
      if (mem_if.o_mem_rd_en) begin
        if (int'(mem_if.o_mem_addr) != base + n_rd) addr_bad++;
        if (n_rd == 0) first_rd = k;
        n_rd++;
      end
      if (o_weight_valid) begin
        if (o_weight !== ram_word(base + n_w)) data_bad++;
        if (n_w == 0) first_v = k;
        last_v = k;
        n_w++;
      end
      if (o_layer_done) done_cyc = k;
      @(posedge clk); #1;
    end
    i_hold = 1'b0; i_layer_req = 1'b0;
    chk({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    chk({tag, "_rd_count"}, 64'(n_rd), 64'(cnt));
    chk({tag, "_addr_seq_bad"}, 64'(addr_bad), 64'd0);
    chk({tag, "_word_count"}, 64'(n_w), 64'(cnt));
    chk({tag, "_data_bad"}, 64'(data_bad), 64'd0);
    chk({tag, "_first_rd"}, 64'(first_rd), 64'd0);
    chk({tag, "_first_valid"}, 64'(first_v), 64'd2);
    chk({tag, "_span"}, 64'(last_v - first_v), 64'(cnt - 1 + hold_len));
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(last_v + 1));
    chk({tag, "_done_one_cycle"}, 64'(o_layer_done), 64'd0);
    chk({tag, "_busy_after"}, 64'(o_busy), 64'd0);
    chk({tag, "_weight_hold"}, 64'(o_weight), 64'(ram_word(base + cnt - 1)));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = ram_word(i);
    rst_n = 1'b0; i_start = 1'b0; i_net_sel = 1'b0; i_layer_req = 1'b0;
    i_hold = 1'b0; i_layer = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_rd_en", 64'(mem_if.o_mem_rd_en), 64'd0);
    chk("rst_addr", 64'(mem_if.o_mem_addr), 64'd0);
    chk("rst_valid", 64'(o_weight_valid), 64'd0);
    chk("rst_weight", 64'(o_weight), 64'd0);
    chk("rst_layer_done", 64'(o_layer_done), 64'd0);
    chk("rst_pass_done", 64'(o_pass_done), 64'd0);
    chk("rst_error", 64'(o_error), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Main bank layer 1: addresses 0..14, contiguous.
    run_burst("l1_main", 2'd1, 1'b0, 0, 15, -1, 0, -1, 2'd0);
    // Target bank layer 2: addresses 79..108.
    run_burst("l2_target", 2'd2, 1'b1, 79, 30, -1, 0, -1, 2'd0);
    chk("l2_no_pass", 64'(o_pass_done), 64'd0);
    // Layer 3 with a 3-cycle hold after five reads.
    run_burst("l3_hold", 2'd3, 1'b0, 45, 18, 5, 3, -1, 2'd0);
    chk("l3_pass_done", 64'(o_pass_done), 64'd1);
    chk("l3_no_error", 64'(o_error), 64'd0);

    // Request while busy: flagged, burst unaffected.
    run_burst("l2_busy_req", 2'd2, 1'b0, 15, 30, -1, 0, 4, 2'd1);
    chk("busy_req_error", 64'(o_error), 64'd1);
    chk("busy_req_pass_kept", 64'(o_pass_done), 64'd1);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("start_clr_error", 64'(o_error), 64'd0);
    chk("start_clr_pass", 64'(o_pass_done), 64'd0);

    // Layer 0 request while idle: flagged and ignored.
    i_layer_req = 1'b1; i_layer = 2'd0;
    @(posedge clk); #1;
    i_layer_req = 1'b0;
    chk("layer0_error", 64'(o_error), 64'd1);
    chk("layer0_busy", 64'(o_busy), 64'd0);
    chk("layer0_rd_en", 64'(mem_if.o_mem_rd_en), 64'd0);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("layer0_start_clr", 64'(o_error), 64'd0);

    // Reset once seven words of layer 1 have come out.
    i_layer_req = 1'b1; i_layer = 2'd1; i_net_sel = 1'b0;
    @(posedge clk); #1;
    i_layer_req = 1'b0;
    n_w = 0;
    for (int k = 0; k < 50 && n_w < 7; k++) begin
      #1;
      if (o_weight_valid) n_w++;
      if (n_w < 7) begin
        @(posedge clk); #1;
      end
    end
    chk("mid_rst_reached", 64'(n_w), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(o_weight_valid), 64'd0);
    chk("mid_rst_weight", 64'(o_weight), 64'd0);
    chk("mid_rst_rd_en", 64'(mem_if.o_mem_rd_en), 64'd0);
    chk("mid_rst_addr", 64'(mem_if.o_mem_addr), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid_later", 64'(o_weight_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_burst("l1_after_rst", 2'd1, 1'b0, 0, 15, -1, 0, -1, 2'd0);

    // Full pass over layers 1, 2, 3 of the main bank.
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    total_words = 0; done_pulses = 0;
    run_burst("pass_l1", 2'd1, 1'b0, 0, 15, -1, 0, -1, 2'd0);
    total_words += n_w; if (done_cyc >= 0) done_pulses++;
    chk("pass_mid1", 64'(o_pass_done), 64'd0);
    run_burst("pass_l2", 2'd2, 1'b0, 15, 30, -1, 0, -1, 2'd0);
    total_words += n_w; if (done_cyc >= 0) done_pulses++;
    run_burst("pass_l3", 2'd3, 1'b0, 45, 18, -1, 0, -1, 2'd0);
    total_words += n_w; if (done_cyc >= 0) done_pulses++;
    chk("pass_total_words", 64'(total_words), 64'd63);
    chk("pass_done_pulses", 64'(done_pulses), 64'd3);
    chk("pass_done_flag", 64'(o_pass_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_weight_sequencer.md
Name: ff_weight_sequencer

Overview:
Weight-streaming controller for the three-layer feed-forward datapath (hidden 1, hidden 2, output).
- On each per-layer weight request from the datapath, it reads that layer's weights from a synchronous-read weight RAM and streams them as a contiguous burst on o_weight/o_weight_valid, including the bias weight of every node.
- It selects between two weight banks (main Q-network / target network) and reports layer and pass completion.
- Sits between the weight RAM and the feed-forward datapath's i_weight/i_weight_valid inputs.

Parameters:
DATA_WIDTH, 32, weight word width (IEEE-754 single).
ADDR_WIDTH, 8, weight RAM address width.
N_IN, 2, input-layer node count.
N_H1, 5, hidden-layer-1 node count.
N_H2, 5, hidden-layer-2 node count.
N_OUT, 3, output-layer node count.
TARGET_BASE, 64, address offset of the target-network bank; must be >= total weight count.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
i_start  in  1  pulse; begins a new pass, clears o_error and o_pass_done.
i_net_sel  in  1  bank select (0 main, 1 target); sampled only on an accepted request.
i_layer_req  in  1  pulse; weight request from the datapath.
i_layer  in  2  requested layer (1 = hidden 1, 2 = hidden 2, 3 = output); sampled with i_layer_req.
i_hold  in  1  when high, no new RAM read is issued.
o_mem_rd_en  out  1  RAM read strobe.
o_mem_addr  out  ADDR_WIDTH  RAM read address.
i_mem_data  in  DATA_WIDTH  RAM read data, valid one cycle after o_mem_rd_en.
o_weight  out  DATA_WIDTH  streamed weight.
o_weight_valid  out  1  o_weight qualifier.
o_busy  out  1  burst in progress.
o_layer_done  out  1  one-cycle pulse after the last weight of a layer.
o_pass_done  out  1  sticky; set when the layer 3 burst completes.
o_error  out  1  sticky; set on an illegal request.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM to IDLE, counters 0. Reset mid-burst aborts the burst immediately; no further valid weights are output.
- Layer word counts (derived constants):
  - C1 = (N_IN+1)*N_H1 = 15
  - C2 = (N_H1+1)*N_H2 = 30
  - C3 = (N_H2+1)*N_OUT = 18
- Layer base addresses: B1 = 0, B2 = C1, B3 = C1+C2. Add TARGET_BASE when the latched bank is 1.
- Word order: node-major. For each node, its input weights come first, then its bias weight, matching the datapath's consumption order.
- FSM states:
  - IDLE: a legal i_layer_req latches layer, bank, base and count; go to FETCH.
  - FETCH:
    - Each cycle with i_hold=0: assert o_mem_rd_en, o_mem_addr = base + rd_cnt, increment rd_cnt.
    - i_hold=1: o_mem_rd_en=0, address held.
    - When rd_cnt reaches count, go to DRAIN.
  - DRAIN: wait for in-flight reads to return; when the last word has been output, pulse o_layer_done and go to IDLE. If the layer was 3, also set o_pass_done.
- Output pipeline: o_weight is registered from i_mem_data, so o_weight_valid is o_mem_rd_en delayed exactly 2 cycles.
  - With i_hold=0 throughout, the burst is contiguous: the first rd_en is in the cycle after the request edge, and exactly count valid words are output.
  - i_hold only inserts gaps; it never drops or duplicates a word.
  - o_layer_done goes high in the cycle after the last o_weight_valid.
- o_busy is 1 in FETCH and DRAIN.
- Illegal requests set o_error and are otherwise ignored (state unchanged):
  - i_layer_req while busy;
  - i_layer == 0.
- i_start while busy: the current burst completes normally, and o_error/o_pass_done are cleared. i_start and o_pass_done setting in the same cycle: the clear wins.
- Address arithmetic is ADDR_WIDTH unsigned. TARGET_BASE + C1 + C2 + C3 must fit; this is a parameter-legality check (elaboration assertion), with no runtime wrap.
- i_mem_data is ignored when no read is in flight. o_weight holds its last value when o_weight_valid = 0.

Decomposition:
- Shared package: layer encoding constants (LAYER_IN=0, LAYER_H1=1, LAYER_H2=2, LAYER_OUT=3), FSM state typedef, and the layer count/base constant functions (C1..C3, B1..B3). These are reused by the weight-update block.
- One natural sub-module: ff_rd_pipe. It is the 2-stage valid/data delay with in-flight counter that tells DRAIN when all reads have returned.

Test Plan:
- Main bank, layer 1, i_hold=0 → rd_en for addresses 0..14; 15 contiguous o_weight_valid starting 2 cycles after the first rd_en; o_weight equals RAM[0..14]; o_layer_done 1 cycle after the last word.
- Target bank, layer 2 → addresses 79..108 (64+15 .. 64+44); 30 words.
- Layer 3 burst with i_hold pulsed high for 3 cycles mid-burst → still exactly 18 words, in order, with a gap; o_pass_done set after the burst.
- i_layer_req during a layer 2 burst, and i_layer_req with i_layer=0 → o_error=1 and the burst unaffected; a following i_start clears o_error.
- rst_n asserted at word 7 of layer 1 → all outputs 0 immediately; a new layer 1 request after reset restarts at address 0.
- Full pass of layers 1, 2, 3 → 63 words total; three o_layer_done pulses; o_pass_done=1 at the end.
